job_pe_mo: RTL

//  Next-generation job processing element for the match engine. Loads one job of JOB_LEN hash results in
//  JOB_LEN/ISSUE_W beats, seeks match heads, issues up to LAZY_LEN match-extension requests back-to-back,

---
 rtl/job_pe_mo.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/job_pe_mo.sv
// Job processing element: loads a job of hash results, extends match heads in a lazy window, emits sequences.
// Build option JOB_PE_MO_LAZY_EN: full LAZY_LEN window; undefined gives greedy matching (window entry 0 only).
module job_pe_mo #(
  parameter int ADDR_W     = 32,
  parameter int JOB_LEN    = 32,
  parameter int ISSUE_W    = 4,
  parameter int LAZY_LEN   = 4,
  parameter int META_LEN_W = 4,
  parameter int META_HIST  = 16,
  parameter int MLEN_W     = 8,
  parameter int OFF_W      = 16,
  parameter int MIN_MATCH  = 4,
  localparam int TAG_W = $clog2(LAZY_LEN),
  localparam int PTR_W = $clog2(JOB_LEN) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDR_W-1:0]             in_head_addr,
  input  logic [ISSUE_W-1:0]            in_hist_valid,
  input  logic [ISSUE_W*ADDR_W-1:0]     in_hist_addr,
  input  logic [ISSUE_W*META_LEN_W-1:0] in_meta_len,
  input  logic [ISSUE_W-1:0]            in_can_ext,
  input  logic                          in_delim,
  output logic                          req_valid,
  input  logic                          req_ready,
  output logic [ADDR_W-1:0]             req_head_addr,
  output logic [ADDR_W-1:0]             req_hist_addr,
  output logic [TAG_W-1:0]              req_tag,
  input  logic                          resp_valid,
  output logic                          resp_ready,
  input  logic [MLEN_W-1:0]             resp_len,
  input  logic [TAG_W-1:0]              resp_tag,
  output logic                          seq_valid,
  input  logic                          seq_ready,
  output logic [PTR_W-1:0]              seq_ll,
  output logic [MLEN_W-1:0]             seq_ml,
  output logic [OFF_W-1:0]              seq_offset,
  output logic                          seq_eoj,
  output logic                          seq_delim,
  output logic [MLEN_W-1:0]             seq_overlap
);
  localparam int IDX_W  = PTR_W - 1;
  localparam int BEATS  = JOB_LEN / ISSUE_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int END_W  = ((MLEN_W > PTR_W) ? MLEN_W : PTR_W) + 1;
`ifdef JOB_PE_MO_LAZY_EN
  localparam int WIN_N = LAZY_LEN;
`else
  localparam int WIN_N = 1;
`endif

  typedef enum logic [2:0] {S_LOAD, S_SEEK, S_ISSUE, S_WAIT, S_EMIT, S_SEND, S_TAIL} state_e;

  state_e                state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [ADDR_W-1:0]     job_head_q, job_head_d;
  logic                  job_delim_q, job_delim_d;
  logic [PTR_W-1:0]      p_q, p_d, seq_ptr_q, seq_ptr_d, match_ptr_q, match_ptr_d;
  logic [LAZY_LEN-1:0]   win_valid_q, win_valid_d, pend_q, pend_d, outst_q, outst_d;
  logic [MLEN_W-1:0]     win_len_q [LAZY_LEN];
  logic [MLEN_W-1:0]     win_len_d [LAZY_LEN];
  logic                  seq_valid_q, seq_valid_d, seq_eoj_q, seq_eoj_d, seq_delim_q, seq_delim_d;
  logic [PTR_W-1:0]      seq_ll_q, seq_ll_d, seq_end_q, seq_end_d;
  logic [MLEN_W-1:0]     seq_ml_q, seq_ml_d, seq_ovl_q, seq_ovl_d;
  logic [OFF_W-1:0]      seq_off_q, seq_off_d;

  logic                  pos_valid_q [JOB_LEN];
  logic                  pos_ext_q   [JOB_LEN];
  logic [META_LEN_W-1:0] pos_len_q   [JOB_LEN];
  logic [OFF_W-1:0]      pos_off_q   [JOB_LEN];
  logic [ADDR_W-1:0]     pos_hist_q  [JOB_LEN];
  logic                  tbl_we;

  function automatic int msb_idx(input logic [OFF_W-1:0] v);
    msb_idx = 0;
    for (int b = 0; b < OFF_W; b++) if (v[b]) msb_idx = b;
  endfunction

  // First valid position at or after match_ptr.
  logic             seek_found;
  logic [PTR_W-1:0] seek_p;
  always_comb begin
    seek_found = 1'b0;
    seek_p     = '0;
    for (int i = JOB_LEN - 1; i >= 0; i--) begin
      if (pos_valid_q[i] && (PTR_W'(i) >= match_ptr_q)) begin
        seek_found = 1'b1;
        seek_p     = PTR_W'(i);
      end
    end
  end

  logic [TAG_W-1:0] iss_k;
  logic [PTR_W-1:0] iss_pos;
  always_comb begin
    iss_k = '0;
    for (int k = LAZY_LEN - 1; k >= 0; k--) if (pend_q[k]) iss_k = TAG_W'(k);
  end
  assign iss_pos = p_q + PTR_W'(iss_k);

  assign in_ready      = (state_q == S_LOAD);
  assign resp_ready    = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign req_valid     = (state_q == S_ISSUE) && (|pend_q);
  assign req_tag       = iss_k;
  assign req_head_addr = job_head_q + ADDR_W'(iss_pos) + ADDR_W'(META_HIST);
  assign req_hist_addr = pos_hist_q[iss_pos[IDX_W-1:0]] + ADDR_W'(META_HIST);

  // Best candidate: highest 4*len - log2(offset), strict compare keeps the lowest k on ties.
  logic             best_found;
  logic [TAG_W-1:0] best_k;
  logic [PTR_W-1:0] best_pos;
  logic [END_W-1:0] best_end;
  always_comb begin
    int               score;
    int               best_score;
    logic [PTR_W-1:0] pos;
    best_found = 1'b0;
    best_k     = '0;
    best_score = 0;
    score      = 0;
    pos        = '0;
    for (int k = 0; k < LAZY_LEN; k++) begin
      pos   = p_q + PTR_W'(k);
      score = 4 * int'(win_len_q[k]) - msb_idx(pos_off_q[pos[IDX_W-1:0]]);
      if (win_valid_q[k] && (win_len_q[k] >= MLEN_W'(MIN_MATCH)) &&
          (!best_found || (score > best_score))) begin
        best_found = 1'b1;
        best_k     = TAG_W'(k);
        best_score = score;
      end
    end
  end
  assign best_pos = p_q + PTR_W'(best_k);
  assign best_end = END_W'(best_pos) + END_W'(win_len_q[best_k]);

  always_comb begin
    logic [PTR_W-1:0] widx;
    logic [MLEN_W:0]  sum;
    // NOTE: every next-state value defaults to its register so no path can infer a latch.
    state_d     = state_q;     beat_d      = beat_q;      job_head_d  = job_head_q;
    job_delim_d = job_delim_q; p_d         = p_q;         seq_ptr_d   = seq_ptr_q;
    match_ptr_d = match_ptr_q; win_valid_d = win_valid_q; pend_d      = pend_q;
    outst_d     = outst_q;     win_len_d   = win_len_q;   seq_valid_d = seq_valid_q;
    seq_ll_d    = seq_ll_q;    seq_ml_d    = seq_ml_q;    seq_off_d   = seq_off_q;
    seq_eoj_d   = seq_eoj_q;   seq_delim_d = seq_delim_q; seq_ovl_d   = seq_ovl_q;
    seq_end_d   = seq_end_q;   tbl_we      = 1'b0;        widx        = '0;
    sum         = '0;
    case (state_q)
      S_LOAD: if (in_valid) begin
        tbl_we = 1'b1;
        beat_d = beat_q + BEAT_W'(1);
        if (beat_q == '0) job_head_d = in_head_addr;
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          job_delim_d = in_delim;
          beat_d      = '0;
          seq_ptr_d   = '0;
          match_ptr_d = '0;
          state_d     = S_SEEK;
        end
      end
      S_SEEK: begin
        if (!seek_found) begin
          seq_valid_d = 1'b1;
          seq_ll_d    = PTR_W'(JOB_LEN) - seq_ptr_q;
          seq_ml_d    = '0;
          seq_off_d   = '0;
          seq_ovl_d   = '0;
          seq_eoj_d   = 1'b1;
          seq_delim_d = job_delim_q;
          state_d     = S_TAIL;
        end else begin
          p_d = seek_p;
          for (int k = 0; k < LAZY_LEN; k++) begin
            widx           = seek_p + PTR_W'(k);
            win_valid_d[k] = (k < WIN_N) && !widx[PTR_W-1] && pos_valid_q[widx[IDX_W-1:0]];
            win_len_d[k]   = win_valid_d[k] ? MLEN_W'(pos_len_q[widx[IDX_W-1:0]]) : '0;
            pend_d[k]      = win_valid_d[k] && pos_ext_q[widx[IDX_W-1:0]];
          end
          outst_d = '0;
          state_d = (|pend_d) ? S_ISSUE : S_WAIT;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (resp_valid && outst_q[resp_tag]) begin
          sum                 = {1'b0, win_len_q[resp_tag]} + {1'b0, resp_len};
          win_len_d[resp_tag] = sum[MLEN_W] ? '1 : sum[MLEN_W-1:0];
          outst_d[resp_tag]   = 1'b0;
        end
        if (req_valid && req_ready) begin
          pend_d[iss_k]  = 1'b0;
          outst_d[iss_k] = 1'b1;
        end
        if (pend_d == '0) state_d = (outst_d == '0) ? S_EMIT : S_WAIT;
      end
      S_EMIT: begin
        if (!best_found) begin
          match_ptr_d = p_q + PTR_W'(1);
          state_d     = S_SEEK;
        end else begin
          seq_valid_d = 1'b1;
          seq_ll_d    = best_pos - seq_ptr_q;
          seq_ml_d    = win_len_q[best_k];
          seq_off_d   = pos_off_q[best_pos[IDX_W-1:0]];
          seq_eoj_d   = (best_end >= END_W'(JOB_LEN));
          seq_ovl_d   = seq_eoj_d ? MLEN_W'(best_end - END_W'(JOB_LEN)) : '0;
          seq_delim_d = job_delim_q && seq_eoj_d;
          seq_end_d   = PTR_W'(best_end);
          state_d     = S_SEND;
        end
      end
      S_SEND: if (seq_ready) begin
        seq_valid_d = 1'b0;
        if (seq_eoj_q) begin
          state_d = S_LOAD;
        end else begin
          seq_ptr_d   = seq_end_q;
          match_ptr_d = seq_end_q;
          state_d     = S_SEEK;
        end
      end
      S_TAIL: if (seq_ready) begin
        seq_valid_d = 1'b0;
        state_d     = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;  beat_q      <= '0;  job_head_q  <= '0;  job_delim_q <= 1'b0;
      p_q         <= '0;      seq_ptr_q   <= '0;  match_ptr_q <= '0;  win_valid_q <= '0;
      pend_q      <= '0;      outst_q     <= '0;  seq_valid_q <= 1'b0; seq_ll_q   <= '0;
      seq_ml_q    <= '0;      seq_off_q   <= '0;  seq_eoj_q   <= 1'b0; seq_delim_q <= 1'b0;
      seq_ovl_q   <= '0;      seq_end_q   <= '0;
      for (int k = 0; k < LAZY_LEN; k++) win_len_q[k] <= '0;
    end else begin
      state_q     <= state_d;     beat_q      <= beat_d;      job_head_q  <= job_head_d;
      job_delim_q <= job_delim_d; p_q         <= p_d;         seq_ptr_q   <= seq_ptr_d;
      match_ptr_q <= match_ptr_d; win_valid_q <= win_valid_d; pend_q      <= pend_d;
      outst_q     <= outst_d;     seq_valid_q <= seq_valid_d; seq_ll_q    <= seq_ll_d;
      seq_ml_q    <= seq_ml_d;    seq_off_q   <= seq_off_d;   seq_eoj_q   <= seq_eoj_d;
      seq_delim_q <= seq_delim_d; seq_ovl_q   <= seq_ovl_d;   seq_end_q   <= seq_end_d;
      win_len_q   <= win_len_d;
    end
  end

  // NOTE: the job table is reset too, so a job abandoned by rst never leaves stale hits behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < JOB_LEN; i++) begin
        pos_valid_q[i] <= 1'b0;
        pos_ext_q[i]   <= 1'b0;
        pos_len_q[i]   <= '0;
        pos_off_q[i]   <= '0;
        pos_hist_q[i]  <= '0;
      end
    end else if (tbl_we) begin
      for (int i = 0; i < ISSUE_W; i++) begin
        pos_valid_q[IDX_W'(int'(beat_q) * ISSUE_W + i)] <= in_hist_valid[i];
        pos_ext_q[IDX_W'(int'(beat_q) * ISSUE_W + i)]   <= in_can_ext[i];
        pos_len_q[IDX_W'(int'(beat_q) * ISSUE_W + i)]   <= in_meta_len[i*META_LEN_W +: META_LEN_W];
        pos_hist_q[IDX_W'(int'(beat_q) * ISSUE_W + i)]  <= in_hist_addr[i*ADDR_W +: ADDR_W];
        pos_off_q[IDX_W'(int'(beat_q) * ISSUE_W + i)]   <=
          OFF_W'(in_head_addr + ADDR_W'(i) - in_hist_addr[i*ADDR_W +: ADDR_W]);
      end
    end
  end

  assign seq_valid   = seq_valid_q;
  assign seq_ll      = seq_ll_q;
  assign seq_ml      = seq_ml_q;
  assign seq_offset  = seq_off_q;
  assign seq_eoj     = seq_eoj_q;
  assign seq_delim   = seq_delim_q;
  assign seq_overlap = seq_ovl_q;
endmodule
